// File: rtl/bsg_arb_req_tracker.sv
// Per-client outstanding-request counters feeding a fixed-priority arbiter's reqs/grants interface.
// Latency: accept or retire is visible on count_o/reqs_o one cycle after the sampling edge.
// Backpressure: req_ready_o drops while a client's counter is saturated; requests while not ready are dropped.
module bsg_arb_req_tracker #(
   parameter int inputs_p      = 4,
   parameter int count_width_p = 2
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [inputs_p-1:0]               req_v_i,
   output logic [inputs_p-1:0]               req_ready_o,
   output logic [inputs_p-1:0]               reqs_o,
   input  logic [inputs_p-1:0]               grants_i,
   output logic [inputs_p*count_width_p-1:0] count_o,
   output logic                              pending_any_o,
   output logic                              err_o
);

   localparam logic [count_width_p-1:0] cnt_max_lp = '1;
   localparam logic [count_width_p-1:0] cnt_one_lp = count_width_p'(1);
   localparam logic [inputs_p-1:0]      vec_one_lp = inputs_p'(1);

   logic [inputs_p-1:0][count_width_p-1:0] cnt_r;
   logic [inputs_p-1:0][count_width_p-1:0] cnt_n;
   logic                                   err_r;
   logic                                   grant_multi;
   logic                                   grant_orphan;
   logic [inputs_p-1:0]                    accept;
   logic [inputs_p-1:0]                    retire;

   // Grant-vector sanity: more than one bit set, or a grant to a client with nothing outstanding.
   always_comb begin
      grant_multi  = (grants_i & (grants_i - vec_one_lp)) != '0;
      grant_orphan = |(grants_i & ~reqs_o);
   end

   // Per-client status from registered state, then accept/retire qualification and next count.
   // Ready depends only on the registered count, so a retire from max never admits a same-cycle request.
   always_comb begin
      for (int k = 0; k < inputs_p; k++) begin
         reqs_o[k]      = (cnt_r[k] != '0);
         req_ready_o[k] = (cnt_r[k] != cnt_max_lp);
         accept[k]      = req_v_i[k] & req_ready_o[k];
         retire[k]      = grants_i[k] & ~grant_multi & reqs_o[k];
         cnt_n[k]       = cnt_r[k];
         if (accept[k] && !retire[k]) begin
            cnt_n[k] = cnt_r[k] + cnt_one_lp;
         end else if (retire[k] && !accept[k]) begin
            cnt_n[k] = cnt_r[k] - cnt_one_lp;
         end
      end
   end

   // Counter and sticky error registers; reset discards all outstanding requests at once.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_r <= '0;
         err_r <= 1'b0;
      end else begin
         cnt_r <= cnt_n;
         err_r <= err_r | grant_multi | grant_orphan;
      end
   end

   assign count_o       = cnt_r;
   assign pending_any_o = |reqs_o;
   assign err_o         = err_r;

endmodule
